// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: icache refill (I) and dcache/LSU (D) share one external bus.
// D has priority; a starvation counter forces an I grant after STARVE_MAX back-to-back D grants.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_iread_en,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_inst,
    output logic        o_iread_vd,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_memaddr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_read_vd,
    output logic        o_write_done,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   tmo_cnt;

    logic d_req;
    logic done_any;
    logic starve_full;
    logic timeout_hit;

    assign d_req       = i_read_en | i_write_en;
    assign done_any    = o_iread_vd | o_read_vd | o_write_done;
    assign starve_full = (starve_cnt == STARVE_TOP);
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    // NOTE: every register here, state and outputs alike, is updated with <= so all
    // right-hand sides see pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            starve_cnt   <= '0;
            tmo_cnt      <= '0;
            o_inst       <= '0;
            o_iread_vd   <= 1'b0;
            o_read_data  <= '0;
            o_read_vd    <= 1'b0;
            o_write_done <= 1'b0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
            o_timeout    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_iread_vd   <= 1'b0;
            o_read_vd    <= 1'b0;
            o_write_done <= 1'b0;
            o_timeout    <= 1'b0;

            case (state)
                IDLE: begin
                    if (!i_iread_en)
                        starve_cnt <= '0;
                    // The completion cycle never grants: the serviced requester may still
                    // hold its level request, and both sides are re-evaluated a cycle later.
                    if (!done_any) begin
                        if (d_req && !(i_iread_en && starve_full)) begin
                            state       <= GNT_D;
                            o_bus_req   <= 1'b1;
                            o_busy      <= 1'b1;
                            o_bus_we    <= i_write_en;
                            o_bus_addr  <= i_memaddr;
                            o_bus_wdata <= i_write_data;
                            tmo_cnt     <= '0;
                            if (i_iread_en)
                                starve_cnt <= starve_cnt + SW'(1);
                        end else if (i_iread_en) begin
                            state      <= GNT_I;
                            o_bus_req  <= 1'b1;
                            o_busy     <= 1'b1;
                            o_bus_we   <= 1'b0;
                            o_bus_addr <= i_iaddr;
                            tmo_cnt    <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end

                GNT_I, GNT_D: begin
                    if (i_bus_ack || timeout_hit) begin
                        state     <= IDLE;
                        o_bus_req <= 1'b0;
                        o_busy    <= 1'b0;
                        o_bus_we  <= 1'b0;
                        o_timeout <= !i_bus_ack;
                        if (state == GNT_I) begin
                            o_iread_vd <= 1'b1;
                            o_inst     <= i_bus_ack ? i_bus_rdata : '0;
                        end else if (o_bus_we) begin
                            o_write_done <= 1'b1;
                        end else begin
                            o_read_vd   <= 1'b1;
                            o_read_data <= i_bus_ack ? i_bus_rdata : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                default: begin
                    state     <= IDLE;
                    o_bus_req <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
